// File: rtl/multicore_pkg.sv
// Shared constants for the multi-core launch controller: core status codes,
// FSM state encoding and the default core count.
package multicore_pkg;

    localparam int NCORES_DEF = 4;

    localparam logic [1:0] ST_OFF = 2'b00;
    localparam logic [1:0] ST_RUN = 2'b01;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/core_finish_tracker.sv
// Per-core sticky finish flag plus the run cycle at which the core first finished.
// Registered outputs; clear has priority and resets the slot for a new run.
module core_finish_tracker #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mask_i,
    input  logic          end_process_i,
    input  logic          run_active_i,
    input  logic          clear_i,
    input  logic [CW-1:0] cycle_count_i,
    output logic          finished_o,
    output logic [CW-1:0] cycle_o
);

    logic          fin_q, fin_d;
    logic [CW-1:0] cyc_q, cyc_d;

    always_comb begin
        fin_d = fin_q;
        cyc_d = cyc_q;
        if (clear_i) begin
            fin_d = 1'b0;
            cyc_d = '0;
        end else if (run_active_i && mask_i && end_process_i && !fin_q) begin
            // First finish only; later edges leave the captured cycle alone.
            fin_d = 1'b1;
            cyc_d = cycle_count_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fin_q <= 1'b0;
            cyc_q <= '0;
        end else begin
            fin_q <= fin_d;
            cyc_q <= cyc_d;
        end
    end

    assign finished_o = fin_q;
    assign cycle_o    = cyc_q;

endmodule

// File: rtl/multicore_launch_ctrl.sv
// Launches a masked set of cores, waits for their end_process flags and reports
// done / timeout / abort with per-core and total run cycle counts.
module multicore_launch_ctrl
    import multicore_pkg::*;
#(
    parameter int NCORES  = NCORES_DEF,
    parameter int CW      = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NCORES-1:0]    core_mask,
    input  logic                 abort,
    input  logic [NCORES-1:0]    end_process,
    output logic [2*NCORES-1:0]  status,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [NCORES-1:0]    finished_mask,
    output logic [CW-1:0]        cycle_count,
    output logic [NCORES*CW-1:0] core_cycles
);

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              to_err_q, to_err_d;

    logic [NCORES-1:0] fin;
    logic [NCORES-1:0] fin_now;
    logic              launch;
    logic              run_active;
    logic              all_fin;
    logic              timeout_hit;

    assign launch      = (state_q == S_IDLE) && start && (|core_mask);
    assign run_active  = (state_q == S_RUN) && !abort;
    assign fin_now     = fin | (mask_q & end_process);
    assign all_fin     = &(fin_now | ~mask_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (all_fin || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_RUN) || (state_q == S_DONE);
        done   = (state_q == S_DONE);
        status = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NCORES; i++) begin
                status[2*i +: 2] = mask_q[i] ? ST_RUN : ST_OFF;
            end
        end
    end

    // Abort freezes the counter on its edge, so the reported count excludes it.
    always_comb begin
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        to_err_d = to_err_q;
        if (launch) begin
            mask_d   = core_mask;
            cnt_d    = '0;
            to_err_d = 1'b0;
        end else if (run_active) begin
            cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
            if (timeout_hit && !all_fin) begin
                to_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        core_finish_tracker #(.CW(CW)) u_trk (
            .clk           (clk),
            .reset_n       (reset_n),
            .mask_i        (mask_q[i]),
            .end_process_i (end_process[i]),
            .run_active_i  (run_active),
            .clear_i       (launch),
            .cycle_count_i (cnt_q),
            .finished_o    (fin[i]),
            .cycle_o       (core_cycles[CW*i +: CW])
        );
    end

    assign finished_mask = fin;
    assign cycle_count   = cnt_q;
    assign timeout_err   = to_err_q;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// Randomized and directed bench for multicore_launch_ctrl against a run-outcome model
// computed from the per-core finish times, abort point and timeout limit.
module tb_multicore_launch_ctrl;

    localparam int NC = 4;
    localparam int CW = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NC-1:0] core_mask = '0;
    logic [NC-1:0] end_process = '0;
    logic [2*NC-1:0]  status;
    logic             busy, done, timeout_err;
    logic [NC-1:0]    finished_mask;
    logic [CW-1:0]    cycle_count;
    logic [NC*CW-1:0] core_cycles;

    logic       s_start = 1'b0;
    logic       s_abort = 1'b0;
    logic [0:0] s_mask = 1'b0;
    logic [0:0] s_end = 1'b0;
    logic [1:0] s_status;
    logic       s_busy, s_done, s_to;
    logic [0:0] s_fin;
    logic [2:0] s_cnt;
    logic [2:0] s_cc;

    int checks = 0;
    int passed = 0;

    multicore_launch_ctrl #(.NCORES(NC), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .core_mask(core_mask),
        .abort(abort), .end_process(end_process), .status(status), .busy(busy),
        .done(done), .timeout_err(timeout_err), .finished_mask(finished_mask),
        .cycle_count(cycle_count), .core_cycles(core_cycles)
    );

    multicore_launch_ctrl #(.NCORES(1), .CW(3), .TIMEOUT(0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(s_start), .core_mask(s_mask),
        .abort(s_abort), .end_process(s_end), .status(s_status), .busy(s_busy),
        .done(s_done), .timeout_err(s_to), .finished_mask(s_fin),
        .cycle_count(s_cnt), .core_cycles(s_cc)
    );

    always #5 clk = ~clk;

    // f[i] = cycle_count value at which core i raises end_process (level, held).
    task automatic run_case(input logic [NC-1:0] mask, input int f0, input int f1,
                            input int f2, input int f3, input int abort_at,
                            input bit pokes, input string name);
        int f[NC];
        int fmax, te, tend, exp_cnt;
        bit ab, exp_to;
        logic [NC-1:0]    exp_fin;
        logic [NC*CW-1:0] exp_cc;
        logic [2*NC-1:0]  exp_status;
        logic [CW-1:0]    fv;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        fmax = -1;
        for (int i = 0; i < NC; i++) if (mask[i] && f[i] > fmax) fmax = f[i];
        te      = (fmax > TO - 1) ? TO - 1 : fmax;
        ab      = (abort_at >= 0) && (abort_at <= te);
        tend    = ab ? abort_at : te;
        exp_cnt = ab ? abort_at : te + 1;
        exp_to  = !ab && (fmax > TO - 1);
        exp_fin = '0; exp_cc = '0; exp_status = '0;
        for (int i = 0; i < NC; i++) begin
            fv = f[i][CW-1:0];
            if (mask[i]) exp_status[2*i +: 2] = 2'b01;
            if (mask[i] && (ab ? (f[i] < abort_at) : (f[i] <= te))) begin
                exp_fin[i] = 1'b1;
                exp_cc[CW*i +: CW] = fv;
            end
        end

        @(negedge clk);
        start = 1'b1; core_mask = mask;
        @(posedge clk); #1;
        start = 1'b0; core_mask = NC'($urandom);
        for (int k = 0; k <= tend; k++) begin
            @(negedge clk);
            checks++;
            if ({status, busy, done, cycle_count} !== {exp_status, 1'b1, 1'b0, CW'(k)})
                $display("FAIL %s run k=%0d: status=%b busy=%b done=%b cnt=%0d want status=%b busy=1 done=0 cnt=%0d",
                         name, k, status, busy, done, cycle_count, exp_status, k);
            else passed++;
            for (int i = 0; i < NC; i++) end_process[i] = mask[i] ? (k >= f[i]) : 1'b1;
            abort = ab && (k == abort_at);
            if (pokes) begin
                start = 1'($urandom); core_mask = NC'($urandom);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        abort = 1'b0; start = 1'b0; end_process = '0;
        if (ab) begin
            checks++;
            if ({busy, done, status} !== '0)
                $display("FAIL %s abort: busy=%b done=%b status=%b want all 0", name, busy, done, status);
            else passed++;
        end else begin
            checks++;
            if ({busy, done, status} !== {1'b1, 1'b1, {2*NC{1'b0}}})
                $display("FAIL %s done: busy=%b done=%b status=%b want busy=1 done=1 status=0",
                         name, busy, done, status);
            else passed++;
            if (pokes) begin
                start = 1'b1; core_mask = NC'($urandom) | NC'(1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, done, status} !== '0)
                $display("FAIL %s post-done: busy=%b done=%b status=%b want all 0", name, busy, done, status);
            else passed++;
        end
        checks++;
        if ({cycle_count, finished_mask, core_cycles, timeout_err} !== {CW'(exp_cnt), exp_fin, exp_cc, exp_to})
            $display("FAIL %s result: cnt=%0d fin=%b cc=%h to=%b want cnt=%0d fin=%b cc=%h to=%b",
                     name, cycle_count, finished_mask, core_cycles, timeout_err,
                     exp_cnt, exp_fin, exp_cc, exp_to);
        else passed++;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({status, busy, done, timeout_err, finished_mask, cycle_count, core_cycles} !== '0)
            $display("FAIL reset: status=%b busy=%b done=%b to=%b fin=%b cnt=%0d cc=%h want all 0",
                     status, busy, done, timeout_err, finished_mask, cycle_count, core_cycles);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_ignored();
        @(negedge clk);
        start = 1'b1; core_mask = '0; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, status} !== '0)
            $display("FAIL ignored_start: busy=%b status=%b want 0", busy, status);
        else passed++;
        run_case(4'b0001, 4, 99, 99, 99, -1, 1'b1, "ignored_core3");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; core_mask = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({status, busy, done, timeout_err, finished_mask, cycle_count, core_cycles} !== '0)
            $display("FAIL reset_mid: status=%b busy=%b done=%b cnt=%0d want all 0",
                     status, busy, done, cycle_count);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        run_case(4'b1010, 1, 3, 1, 6, -1, 1'b0, "after_reset");
    endtask

    task automatic test_saturate();
        @(negedge clk);
        s_start = 1'b1; s_mask = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_cnt, s_busy} !== {3'd7, 1'b1})
            $display("FAIL saturate: cnt=%0d busy=%b want cnt=7 busy=1", s_cnt, s_busy);
        else passed++;
        s_end = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        s_end = 1'b0;
        checks++;
        if ({s_done, s_cnt, s_cc, s_fin, s_to} !== {1'b1, 3'd7, 3'd7, 1'b1, 1'b0})
            $display("FAIL saturate_done: done=%b cnt=%0d cc=%0d fin=%b to=%b want 1 7 7 1 0",
                     s_done, s_cnt, s_cc, s_fin, s_to);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [NC-1:0] m;
        int ab;
        for (int n = 0; n < 20; n++) begin
            m  = NC'($urandom_range(1, 15));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : -1;
            run_case(m, $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 24),
                     $urandom_range(0, 24), ab, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        run_case(4'b0111, 5, 9, 7, 99, -1, 1'b0, "basic_0111");
        run_case(4'b0011, 3, 99, 99, 99, -1, 1'b0, "timeout");
        run_case(4'b1111, 99, 99, 99, 99, 4, 1'b0, "abort");
        test_ignored();
        run_case(4'b0011, 2, 6, 99, 99, 6, 1'b0, "abort_vs_finish");
        run_case(4'b0001, 19, 99, 99, 99, -1, 1'b0, "finish_vs_timeout");
        run_case(4'b1111, 0, 0, 0, 0, -1, 1'b0, "min_run");
        run_case(4'b1001, 2, 0, 0, 1, -1, 1'b1, "back_to_back");
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicore_launch_ctrl.md
# multicore_launch_ctrl

Host-side launch controller for the multi-core matrix-multiplication processor. It drives the per-core 2-bit status inputs, waits for each enabled core's end_process flag, records per-core and total run cycles, and reports completion, timeout or abort. It sits between the host/bench and the `processor` top. It replaces hand-driven status registers in benches and the board wrapper.

## Interface

Parameters:
- NCORES, 4, number of cores; status and end_process widths scale with it
- CW, 16, width of cycle counters
- TIMEOUT, 0, run-cycle limit; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle launch request
- core_mask  in  NCORES  cores to launch; bit i = core i
- abort  in  1  force-stop request
- end_process  in  NCORES  level completion flag from each core
- status  out  2*NCORES  core i status at [2i+1:2i]; 2'b00 = off, 2'b01 = run
- busy  out  1  run in progress (RUN or DONE state)
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  last run ended by timeout
- finished_mask  out  NCORES  cores seen finished in the current or last run
- cycle_count  out  CW  total RUN cycles of the current or last run
- core_cycles  out  NCORES*CW  core i finish cycle at [CW*(i+1)-1:CW*i]

## Operation

FSM states: IDLE, RUN, DONE.
- IDLE: all status = 00. start=1 with core_mask != 0 latches the mask, then does the following:
  - clears finished_mask, cycle_count, core_cycles and timeout_err.
  - moves to RUN.
  - start with core_mask = 0 is ignored.
- RUN: status = 01 for masked cores and 00 for others. cycle_count increments once per cycle and saturates at all-ones.
  - On the first edge where core i is masked and end_process[i]=1, set finished_mask[i] and write the pre-increment cycle_count into core_cycles[i]. That slot is not written again during this run.
  - end_process of unmasked cores is ignored.
- All masked cores finished → DONE, with that core's status dropping to 00 on the same edge.
- TIMEOUT != 0 and cycle_count = TIMEOUT-1 with cores still unfinished → DONE, timeout_err=1.
- abort=1 in RUN → IDLE directly. No done pulse. finished_mask and counters hold their values.
- DONE: lasts one cycle with done=1 and all status 00, then IDLE.
- start in RUN or DONE is ignored. abort in IDLE or DONE is ignored.
- Contract with cores: a core holds end_process low while its status is 00. The controller performs no extra stale-flag filtering.

Simultaneous events:
- abort and the last finish on the same edge: abort wins, IDLE, no done.
- Last finish and timeout on the same edge: finish wins, timeout_err=0.

## Timing

- Reset (reset_n low, async): state IDLE and every output is 0, i.e. status=0, busy=0, done=0, timeout_err=0, finished_mask=0, cycle_count=0, core_cycles=0.
- All outputs are registered. end_process is used unregistered.
- start sampled at edge E0:
  - status=01 and busy=1 are visible after E0.
  - cycle_count reads 1 after E1.
- Last end_process sampled at edge En: state DONE after En, done=1 for exactly one cycle, status 00.
- busy=0 and IDLE after En+1. A new start is accepted at En+2 at the earliest.
- Minimum run, with every core finishing at the first RUN edge: start→done is 2 cycles.
- Reset asserted mid-run returns immediately to the reset values. No done pulse.

## Structure

- Package `multicore_pkg` holds:
  - ST_OFF = 2'b00 and ST_RUN = 2'b01.
  - The FSM state encoding (IDLE, RUN, DONE as 2-bit localparams).
  - Default NCORES.
- Sub-module `core_finish_tracker`, one instance per core, generate loop. Inputs: mask bit, end_process bit, run-active, clear, shared cycle_count. Outputs: the sticky finished bit and the latched CW-bit finish cycle.
- The top holds the FSM, the shared counter, the timeout compare and the status packing.

## Test plan

- Mask 4'b0111, cores 0/1/2 raise end_process after 5/9/7 RUN cycles → finished_mask=0111, core_cycles=5/9/7, done one pulse, cycle_count=10, status3 stays 00 throughout.
- TIMEOUT=20, mask 4'b0011, only core 0 finishes (cycle 3) → DONE after cycle_count=20, timeout_err=1, finished_mask=0001, core_cycles[1]=0.
- Abort at RUN cycle 4, mask 4'b1111 → IDLE next cycle, no done, status=0, cycle_count=4.
- start with core_mask=0, then start during RUN, then end_process[3] high with mask 4'b0001 → all ignored, no state change, finished_mask[3]=0.
- Last finish and abort on the same edge → no done, IDLE. Last finish and TIMEOUT on the same edge → done=1, timeout_err=0.
- reset_n pulsed low mid-RUN (asynchronous, between edges) → all outputs 0 immediately. A fresh start afterwards runs normally.
